// File: rtl/exc_sequencer.sv
// Exception/interrupt sequencer between the M stage and CP0.
// Picks one event per trigger (interrupt > exception > eret), pulses the
// CP0 EXL strobe on the first flush cycle, holds flush for FLUSH_CYCLES
// cycles and then issues a single-cycle PC redirect.
// Every output comes straight from a register, so there is no
// combinational path from any input to any output.
module exc_sequencer #(
    parameter logic [31:0] HANDLER_PC   = 32'h0000_4180,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_bd,
    input  logic [4:0]  m_exc,
    input  logic        m_eret,
    input  logic        int_req,
    input  logic [31:0] epc,
    output logic        cp0_exl_set,
    output logic        cp0_exl_clr,
    output logic [4:0]  cp0_exccode,
    output logic [31:0] cp0_pc,
    output logic        cp0_bd,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  count_r;
    logic [3:0]  count_s;
    logic [31:0] target_r;
    logic [31:0] target_s;

    logic        exl_set_s;
    logic        exl_clr_s;
    logic [4:0]  exccode_s;
    logic [31:0] pc_s;
    logic        bd_s;
    logic        flush_s;
    logic        redirect_valid_s;
    logic [31:0] redirect_pc_s;
    logic        busy_s;

    logic        int_hit_s;
    logic        exc_hit_s;
    logic        eret_hit_s;

    // Qualify every request with a real (non-bubble) M-stage slot.
    always_comb begin
        int_hit_s  = m_valid & int_req;
        exc_hit_s  = m_valid & (m_exc != 5'd0);
        eret_hit_s = m_valid & m_eret;
    end

    // Next-state and next-output decode; outputs are registered below.
    always_comb begin
        state_s          = state_r;
        count_s          = count_r;
        target_s         = target_r;
        exl_set_s        = 1'b0;
        exl_clr_s        = 1'b0;
        exccode_s        = cp0_exccode;
        pc_s             = cp0_pc;
        bd_s             = cp0_bd;
        flush_s          = 1'b0;
        redirect_valid_s = 1'b0;
        redirect_pc_s    = redirect_pc;
        busy_s           = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (int_hit_s || exc_hit_s || eret_hit_s) begin
                    state_s = ST_FLUSH;
                    count_s = FLUSH_INIT;
                    pc_s    = m_pc;
                    bd_s    = m_bd;
                    flush_s = 1'b1;
                    busy_s  = 1'b1;
                    if (int_hit_s) begin
                        exccode_s = 5'd0;
                        target_s  = HANDLER_PC;
                        exl_set_s = 1'b1;
                    end else if (exc_hit_s) begin
                        exccode_s = m_exc;
                        target_s  = HANDLER_PC;
                        exl_set_s = 1'b1;
                    end else begin
                        // eret carries no cause; EPC was sampled this edge
                        exccode_s = 5'd0;
                        target_s  = epc;
                        exl_clr_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                busy_s  = 1'b1;
                count_s = count_r - 4'd1;
                if (count_r <= 4'd1) begin
                    state_s          = ST_REDIRECT;
                    redirect_valid_s = 1'b1;
                    redirect_pc_s    = target_r;
                end else begin
                    flush_s = 1'b1;
                end
            end
            ST_REDIRECT: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                count_s = 4'd0;
            end
        endcase
    end

    // FSM state, flush counter and captured redirect target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            count_r  <= 4'd0;
            target_r <= 32'd0;
        end else begin
            state_r  <= state_s;
            count_r  <= count_s;
            target_r <= target_s;
        end
    end

    // Registered outputs towards CP0 and the fetch/pipeline control.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cp0_exl_set    <= 1'b0;
            cp0_exl_clr    <= 1'b0;
            cp0_exccode    <= 5'd0;
            cp0_pc         <= 32'd0;
            cp0_bd         <= 1'b0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            busy           <= 1'b0;
        end else begin
            cp0_exl_set    <= exl_set_s;
            cp0_exl_clr    <= exl_clr_s;
            cp0_exccode    <= exccode_s;
            cp0_pc         <= pc_s;
            cp0_bd         <= bd_s;
            flush          <= flush_s;
            redirect_valid <= redirect_valid_s;
            redirect_pc    <= redirect_pc_s;
            busy           <= busy_s;
        end
    end

endmodule

// File: doc/exc_sequencer.md
# exc_sequencer

Exception/interrupt sequencer between the pipeline's memory stage and the CP0 register block. It picks one event per trigger: an interrupt, a synchronous exception or an `eret`. It then pulses the CP0 EXL strobes with the captured PC, branch-delay flag and ExcCode, and holds a pipeline flush for a fixed number of cycles. Last, it issues a single-cycle PC redirect to either the handler vector or the saved EPC.

## Interface
Parameters:
- `HANDLER_PC`, default `32'h0000_4180`: exception/interrupt handler entry address.
- `FLUSH_CYCLES`, default `2`: number of cycles `flush` is held. Legal range is 1..15. The counter is 4 bits.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `m_valid`  in  1  the M-stage slot holds a real instruction (not a bubble).
- `m_pc`  in  32  PC of the M-stage instruction.
- `m_bd`  in  1  the M-stage instruction sits in a branch delay slot.
- `m_exc`  in  5  ExcCode of the M-stage instruction. 0 means no exception.
- `m_eret`  in  1  the M-stage instruction is `eret`.
- `int_req`  in  1  interrupt request from CP0 (already masked by IM/IE/EXL).
- `epc`  in  32  current EPC from CP0, word-aligned.
- `cp0_exl_set`  out  1  one-cycle pulse: CP0 records the exception and sets EXL.
- `cp0_exl_clr`  out  1  one-cycle pulse: CP0 clears EXL (`eret`).
- `cp0_exccode`  out  5  ExcCode for CP0. 0 for interrupts.
- `cp0_pc`  out  32  PC handed to CP0.
- `cp0_bd`  out  1  branch-delay flag handed to CP0.
- `flush`  out  1  kill F/D/E/M stage contents.
- `redirect_valid`  out  1  one-cycle PC-override pulse.
- `redirect_pc`  out  32  fetch target; valid while `redirect_valid`=1.
- `busy`  out  1  the sequencer is not in IDLE.

## Operation
- FSM states are IDLE, FLUSH and REDIRECT.
- IDLE trigger is evaluated only when `m_valid`=1. Priority from highest to lowest:
  - `int_req`=1: kind INT, code 0, target `HANDLER_PC`.
  - `m_exc`≠0: kind EXC, code `m_exc`, target `HANDLER_PC`.
  - `m_eret`=1: kind ERET, target `epc`.
- On a trigger, the block captures `m_pc`, `m_bd`, code, kind and target into registers, loads counter = `FLUSH_CYCLES`, and moves to FLUSH.
- If `m_valid`=0, every request is ignored that cycle. An interrupt stays pending at CP0 and is taken on the next valid slot.
- FLUSH:
  - `flush`=1 every cycle.
  - Counter decrements each cycle; when it reaches 1, the next state is REDIRECT.
  - On the first FLUSH cycle only:
    - For INT/EXC: `cp0_exl_set`=1, with `cp0_exccode`/`cp0_pc`/`cp0_bd` showing the captured values.
    - For ERET: `cp0_exl_clr`=1.
- REDIRECT: `redirect_valid`=1 and `redirect_pc`=captured target for one cycle, then return to IDLE. `flush`=0 in REDIRECT.
- While `busy`=1, all inputs are ignored. No nesting and no re-trigger.
- `cp0_exccode`, `cp0_pc` and `cp0_bd` hold their captured values until the next trigger.
- `cp0_bd` is passed through unchanged; the EPC adjustment for delay slots is CP0's job.
- The sequencer never asserts `cp0_exl_set` and `cp0_exl_clr` in the same cycle.

## Timing
- Reset values: state IDLE, counter 0, and all outputs 0 (including `redirect_pc`, `cp0_pc`, `cp0_exccode` and `cp0_bd`).
- Reset asserted mid-sequence aborts immediately: no strobe and no redirect are issued afterwards.
- Cycle sequence for a trigger sampled at the clock edge ending cycle T:
  - Cycles T+1..T+`FLUSH_CYCLES`: FLUSH (`flush`=1).
  - Cycle T+1: strobe pulse.
  - Cycle T+`FLUSH_CYCLES`+1: REDIRECT.
  - Cycle T+`FLUSH_CYCLES`+2: IDLE, and a new trigger can be evaluated.
- `busy`=1 during T+1..T+`FLUSH_CYCLES`+1.
- Minimum spacing between two triggers is `FLUSH_CYCLES`+2 cycles.
- All outputs are registered or decoded from state only. There are no combinational input-to-output paths.
- `epc` is sampled at the trigger edge. Later CP0 writes do not affect the redirect target.

## Test plan
- **Exception:** `m_valid`=1, `m_exc`=4, `m_pc`=0x3008, `m_bd`=0, defaults. Required: T+1 `cp0_exl_set`=1, `cp0_exccode`=4, `cp0_pc`=0x3008; `flush`=1 at T+1..T+2; T+3 `redirect_valid`=1, `redirect_pc`=0x4180; `busy` low at T+4.
- **Priority:** `int_req`=1 together with `m_exc`=10, `m_eret`=1, `m_pc`=0x3010, `m_bd`=1. Required: `cp0_exccode`=0, `cp0_bd`=1, `cp0_exl_clr` never pulses, `redirect_pc`=0x4180.
- **eret:** `m_eret`=1, `epc`=0x3020. Required: T+1 `cp0_exl_clr`=1 and `cp0_exl_set`=0; `redirect_pc`=0x3020. Changing `epc` to 0x5000 at T+1 still redirects to 0x3020.
- **Bubble gating:** `int_req`=1 with `m_valid`=0 for 3 cycles, then `m_valid`=1 with `m_pc`=0x3100. Required: no activity during the 3 cycles; then trigger with `cp0_pc`=0x3100.
- **Busy lockout and FLUSH_CYCLES=1:** a second `m_exc`=12 arrives during FLUSH and is ignored. With `FLUSH_CYCLES`=1: exactly one `flush` cycle, and redirect at T+2.
- **Reset abort:** `rst` pulsed at T+1 of an exception sequence. Required: all outputs 0 immediately, no `redirect_valid` afterwards, state IDLE.
